// File: rtl/spi_resp.sv
// SPI mode-0 responder: oversamples the SPI pins in the clk100 domain, deserialises
// MOSI into words and serialises fabric-supplied words (or FILL) onto MISO.
module spi_resp #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
    input  logic              clk100,
    input  logic              rstn,
    input  logic              sclk_i,
    input  logic              csn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              underrun_o,
    output logic              frame_err_o
);
    localparam int            CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_n;
    logic [2:0]        sclk_s, csn_s, mosi_s;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh, hold, rx_next;
    logic              hold_full;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              do_load, do_shift, do_sample, do_abort, go_idle, clr_cnt;

    // [0],[1] synchronise, [2] is the edge-detect delay; CS syncs reset to "asserted"
    // so a pin already low at reset release is not mistaken for a new frame start.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            sclk_s <= '0;
            csn_s  <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk_i};
            csn_s  <= {csn_s[1:0], csn_i};
            mosi_s <= {mosi_s[1:0], mosi_i};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_fall   = ~csn_s[1] & csn_s[2];
    assign cs_rise   = csn_s[1] & ~csn_s[2];

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_sample = 1'b0;
        do_abort  = 1'b0;
        go_idle   = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = ACTIVE;
                    do_load = 1'b1;
                    clr_cnt = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_n  = IDLE;
                    go_idle  = 1'b1;
                    clr_cnt  = 1'b1;
                    do_abort = (cnt != '0);
                end else begin
                    do_sample = sclk_rise;
                    if (sclk_fall) begin
                        do_load  = (cnt == '0);
                        do_shift = (cnt != '0);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_next = {rx_sh[DATA_W-2:0], mosi_s[2]};

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            tx_sh       <= '0;
            rx_sh       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            cnt         <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            underrun_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_valid_o  <= 1'b0;
            underrun_o  <= 1'b0;
            frame_err_o <= do_abort;
            // Accept only into an empty register, so it can never collide with a
            // load draining a full one; a same-cycle load still sees "empty".
            if (tx_valid_i && !hold_full) begin
                hold      <= tx_data_i;
                hold_full <= 1'b1;
            end
            if (do_load) begin
                if (hold_full) begin
                    tx_sh     <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_sh      <= FILL;
                    underrun_o <= 1'b1;
                end
            end else if (do_shift) begin
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end else if (go_idle) begin
                tx_sh <= '0;
            end
            if (clr_cnt) begin
                cnt <= '0;
            end else if (do_sample) begin
                rx_sh <= rx_next;
                if (cnt == LAST) begin
                    cnt        <= '0;
                    rx_data_o  <= rx_next;
                    rx_valid_o <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign miso_o     = (state == ACTIVE) ? tx_sh[DATA_W-1] : 1'b0;
    assign busy_o     = (state == ACTIVE);
    assign tx_ready_o = ~hold_full;
endmodule

// File: tb/tb_spi_resp.sv
// Bench for spi_resp: bit-banged SPI master, TX holding-register model and
// scoreboard queues for rx words, underrun and frame-error pulses.
module tb_spi_resp;
    logic       clk100 = 1'b0;
    logic       rstn   = 1'b0;
    logic       sclk   = 1'b0;
    logic       csn    = 1'b1;
    logic       mosi   = 1'b0;
    logic       miso;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, underrun, frame_err;

    int total = 0;
    int passed = 0;

    // Reference state: one-entry holding register plus expected-event queues.
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic [7:0] exp_rx[$];
    bit         exp_und[$];
    bit         exp_fe[$];

    logic [7:0] mw[4];
    bit         push_e[4];
    logic [7:0] push_d[4];

    spi_resp #(.DATA_W(8), .FILL(8'hFF)) dut (
        .clk100(clk100), .rstn(rstn), .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi),
        .miso_o(miso), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
        .underrun_o(underrun), .frame_err_o(frame_err)
    );

    always #5 clk100 = ~clk100;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk100);
            #1;
        end
    endtask

    // Model of a word load: holding register if full, otherwise FILL plus an underrun.
    function automatic logic [7:0] do_load();
        logic [7:0] w;
        if (hold_v) begin
            w      = hold_d;
            hold_v = 1'b0;
        end else begin
            w = 8'hFF;
            exp_und.push_back(1'b1);
        end
        return w;
    endfunction

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 20) begin
            cyc(1);
            n++;
        end
        chk("tx_ready_before_push", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        hold_v   = 1'b1;
        hold_d   = d;
    endtask

    // Master frame of nbits (not a multiple of 8 -> aborted word). With sim set,
    // tx_valid is driven in exactly the cycle the CS-fall load happens.
    task automatic spi_frame(input int nbits, input bit sim, input logic [7:0] sim_d);
        logic [7:0] cur, cap;
        int i, j;
        cur = do_load();
        csn = 1'b0;
        if (sim) begin
            cyc(2);
            tx_data  = sim_d;
            tx_valid = 1'b1;
            cyc(1);
            tx_valid = 1'b0;
            hold_v   = 1'b1;
            hold_d   = sim_d;
            cyc(2);
        end else begin
            cyc(5);
        end
        chk("busy_in_frame", busy, 1);
        cap = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            i = b / 8;
            j = b % 8;
            mosi = mw[i][7-j];
            cyc(5);
            cap = {cap[6:0], miso};
            if (j == 7) exp_rx.push_back(mw[i]);
            sclk = 1'b1;
            cyc(3);
            if (j == 3 && push_e[i] && !hold_v) push_tx(push_d[i]);
            else cyc(1);
            cyc(1);
            sclk = 1'b0;
            if (j == 7) begin
                chk("miso_word", cap, cur);
                cur = do_load();
            end
        end
        mosi = 1'b0;
        cyc(5);
        if (nbits % 8 != 0) exp_fe.push_back(1'b1);
        csn = 1'b1;
        cyc(8);
        chk("rx_pending_after_frame", exp_rx.size(), 0);
        chk("underrun_pending_after_frame", exp_und.size(), 0);
        chk("frame_err_pending_after_frame", exp_fe.size(), 0);
        chk("busy_after_frame", busy, 0);
        chk("tx_ready_after_frame", tx_ready, !hold_v);
        chk("miso_idle", miso, 0);
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge clk100) begin
        if (rstn) begin
            if (rx_valid) begin
                chk("rx_valid_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) chk("rx_data", rx_data, exp_rx.pop_front());
            end
            if (underrun) begin
                chk("underrun_expected", exp_und.size() != 0, 1);
                if (exp_und.size() != 0) void'(exp_und.pop_front());
            end
            if (frame_err) begin
                chk("frame_err_expected", exp_fe.size() != 0, 1);
                if (exp_fe.size() != 0) void'(exp_fe.pop_front());
            end
        end
    end

    task automatic clear_plan();
        for (int k = 0; k < 4; k++) begin
            push_e[k] = 1'b0;
            push_d[k] = 8'h00;
        end
    endtask

    initial begin
        int nw, nb;
        clear_plan();
        // Reset and idle state
        cyc(4);
        chk("rst_miso", miso, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_frame_err", frame_err, 0);
        rstn = 1'b1;
        cyc(6);
        chk("post_rst_tx_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Single word
        push_tx(8'hA5);
        chk("tx_ready_full", tx_ready, 0);
        mw[0] = 8'h3C;
        spi_frame(8, 1'b0, 8'h00);

        // Multi-word frame; 8'h33 is queued for the trailing load so only the third load underruns
        push_tx(8'h11);
        mw[0] = 8'h01; mw[1] = 8'h02; mw[2] = 8'h03;
        push_e[0] = 1'b1; push_d[0] = 8'h22;
        push_e[2] = 1'b1; push_d[2] = 8'h33;
        spi_frame(24, 1'b0, 8'h00);
        clear_plan();

        // Aborted word, then a clean frame
        mw[0] = 8'hC3;
        spi_frame(5, 1'b0, 8'h00);
        push_tx(8'h5E);
        mw[0] = 8'h96;
        spi_frame(8, 1'b0, 8'h00);

        // Accept coinciding with the CS-fall load
        mw[0] = 8'h4B; mw[1] = 8'hB4;
        spi_frame(16, 1'b1, 8'h77);

        // Reset mid-frame after bit 3, released with CS still low
        push_tx(8'h5A);
        void'(do_load());
        csn = 1'b0;
        cyc(5);
        for (int b = 0; b < 3; b++) begin
            mosi = b[0];
            cyc(5);
            sclk = 1'b1;
            cyc(5);
            sclk = 1'b0;
        end
        cyc(2);
        rstn = 1'b0;
        hold_v = 1'b0;
        cyc(2);
        chk("midrst_miso", miso, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        rstn = 1'b1;
        cyc(10);
        chk("no_false_start", busy, 0);
        chk("no_false_start_miso", miso, 0);
        csn = 1'b1;
        cyc(6);
        push_tx(8'hE1);
        mw[0] = 8'h2D; mw[1] = 8'hD2;
        spi_frame(16, 1'b0, 8'h00);

        // Randomised frames
        for (int f = 0; f < 25; f++) begin
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                mw[k]     = 8'($urandom);
                push_e[k] = 1'($urandom);
                push_d[k] = 8'($urandom);
            end
            if (!hold_v && $urandom_range(0, 1) == 1) push_tx(8'($urandom));
            nb = nw * 8;
            if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
            spi_frame(nb, 1'b0, 8'h00);
            cyc($urandom_range(2, 10));
        end
        clear_plan();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
